// File: rtl/enc_defines.sv
// Shared constants, component codes and FSM encodings for the SAO band-offset statistic block.
package enc_defines;
  localparam int SAO_BO_BAND_SHIFT = 3;
  localparam int SAO_BO_BAND_NUM   = 4;
  localparam int SAO_BO_SUM_W      = 21;
  localparam int SAO_BO_CNT_W      = 13;
  localparam int SAO_BO_PIX_NUM    = 32;

  localparam logic [1:0] COMP_Y = 2'd0;
  localparam logic [1:0] COMP_U = 2'd1;
  localparam logic [1:0] COMP_V = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } sao_bo_state_e;

  // Code 3 falls through to the luma band.
  function automatic logic [4:0] sel_first_band(input logic [1:0] comp, input logic [14:0] pre);
    case (comp)
      COMP_U:  return pre[9:5];
      COMP_V:  return pre[14:10];
      default: return pre[4:0];
    endcase
  endfunction
endpackage

// File: rtl/sao_bo_pixel_class.sv
// Classifies one rec/org pixel pair into one of four bands starting at first_band.
module sao_bo_pixel_class
  import enc_defines::*;
(
  input  logic [7:0] rec_i,
  input  logic [7:0] org_i,
  input  logic [4:0] first_band_i,
  output logic       hit_o,
  output logic [1:0] k_o,
  output logic [8:0] diff_o
);
  logic [4:0] band;
  logic [4:0] k5;

  assign band   = rec_i[7:SAO_BO_BAND_SHIFT];
  // Wraps in 5 bits; the >= test rejects bands below first_band.
  assign k5     = band - first_band_i;
  assign hit_o  = (band >= first_band_i) && (k5 < 5'(SAO_BO_BAND_NUM));
  assign k_o    = k5[1:0];
  assign diff_o = {1'b0, org_i} - {1'b0, rec_i};
endmodule

// File: rtl/sao_bo_statistic.sv
// SAO band-offset statistic: per-pass sums/counts of org-rec over four bands.
// Optional SAO_BO_PIPE_EN adds a register stage between classification and accumulation.
module sao_bo_statistic
  import enc_defines::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [1:0]   comp_i,
  input  logic [14:0]  bo_predecision_i,
  input  logic         valid_i,
  input  logic         last_i,
  input  logic [255:0] rec_i,
  input  logic [255:0] org_i,
  output logic [83:0]  sum_o,
  output logic [51:0]  cnt_o,
  output logic [1:0]   comp_o,
  output logic         done_o
);
  localparam int NPIX = SAO_BO_PIX_NUM;

  sao_bo_state_e state_q, state_d;
  logic [4:0] first_band_q;
  logic [1:0] comp_q;
  logic [SAO_BO_BAND_NUM-1:0][SAO_BO_SUM_W-1:0] sum_q, sum_d, beat_sum;
  logic [SAO_BO_BAND_NUM-1:0][SAO_BO_CNT_W-1:0] cnt_q, cnt_d, beat_cnt;

  logic [NPIX-1:0]      hit_c, hit_s;
  logic [NPIX-1:0][1:0] k_c, k_s;
  logic [NPIX-1:0][8:0] diff_c, diff_s;
  logic vld_s, last_s, pend, qual, start_acc;

  // pend: the final beat sits in the pipe register, so the pass is committed.
  assign start_acc = start_i && ((state_q == ST_IDLE) || ((state_q == ST_ACC) && !pend));
  assign qual      = (state_q == ST_ACC) && valid_i && !start_i && !pend;

  for (genvar n = 0; n < NPIX; n++) begin : g_pix
    sao_bo_pixel_class u_pix (
      .rec_i        (rec_i[8*n +: 8]),
      .org_i        (org_i[8*n +: 8]),
      .first_band_i (first_band_q),
      .hit_o        (hit_c[n]),
      .k_o          (k_c[n]),
      .diff_o       (diff_c[n])
    );
  end

`ifdef SAO_BO_PIPE_EN
  logic [NPIX-1:0]      hit_q;
  logic [NPIX-1:0][1:0] k_q;
  logic [NPIX-1:0][8:0] diff_q;
  logic                 vld_q, last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0; k_q <= '0; diff_q <= '0; vld_q <= 1'b0; last_q <= 1'b0;
    end else if (start_acc) begin
      hit_q <= '0; vld_q <= 1'b0; last_q <= 1'b0;
    end else begin
      hit_q  <= hit_c;
      k_q    <= k_c;
      diff_q <= diff_c;
      vld_q  <= qual;
      last_q <= qual && last_i;
    end
  end

  assign hit_s  = hit_q;
  assign k_s    = k_q;
  assign diff_s = diff_q;
  assign vld_s  = vld_q;
  assign last_s = last_q;
  assign pend   = vld_q && last_q;
`else
  assign hit_s  = hit_c;
  assign k_s    = k_c;
  assign diff_s = diff_c;
  assign vld_s  = qual;
  assign last_s = last_i;
  assign pend   = 1'b0;
`endif

  always_comb begin
    beat_sum = '0;
    beat_cnt = '0;
    for (int b = 0; b < SAO_BO_BAND_NUM; b++)
      for (int n = 0; n < NPIX; n++)
        if (hit_s[n] && (k_s[n] == 2'(b))) begin
          beat_sum[b] = beat_sum[b] + SAO_BO_SUM_W'($signed(diff_s[n]));
          beat_cnt[b] = beat_cnt[b] + SAO_BO_CNT_W'(1);
        end
  end

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (start_acc) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (vld_s) begin
      for (int b = 0; b < SAO_BO_BAND_NUM; b++) begin
        sum_d[b] = sum_q[b] + beat_sum[b];
        cnt_d[b] = cnt_q[b] + beat_cnt[b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      first_band_q <= '0;
      comp_q       <= '0;
      sum_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      if (start_acc) begin
        comp_q       <= comp_i;
        first_band_q <= sel_first_band(comp_i, bo_predecision_i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_ACC;
      ST_ACC:  if (!start_acc && vld_s && last_s) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb done_o = (state_q == ST_OUT);

  assign sum_o  = sum_q;
  assign cnt_o  = cnt_q;
  assign comp_o = comp_q;
endmodule

// File: tb/tb_sao_bo_statistic.sv
// Table-driven bench with an expected-result queue popped on done_o.
module tb_sao_bo_statistic;
  logic         clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, valid_i = 1'b0, last_i = 1'b0;
  logic [1:0]   comp_i = '0;
  logic [14:0]  pre = '0;
  logic [255:0] rec_i = '0, org_i = '0;
  logic [83:0]  sum_o;
  logic [51:0]  cnt_o;
  logic [1:0]   comp_o;
  logic         done_o;

`ifdef SAO_BO_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  sao_bo_statistic dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .comp_i(comp_i), .bo_predecision_i(pre),
    .valid_i(valid_i), .last_i(last_i), .rec_i(rec_i), .org_i(org_i),
    .sum_o(sum_o), .cnt_o(cnt_o), .comp_o(comp_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  comp;
    logic [14:0] pre;
    int nb;
    int r[8];
    int d[8];
    int es[4];
    int ec[4];
  } vec_t;
  typedef struct {
    logic [1:0] comp;
    int es[4];
    int ec[4];
  } exp_t;

  vec_t vt[7];
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0, run_len = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input exp_t x);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_sum%0d", tag, k), int'($signed(sum_o[21*k +: 21])), x.es[k]);
      chk($sformatf("%s_cnt%0d", tag, k), int'(cnt_o[13*k +: 13]), x.ec[k]);
    end
    chk({tag, "_comp"}, int'(comp_o), int'(x.comp));
  endtask

  task automatic push_exp(input vec_t v);
    exp_t x;
    x.comp = v.comp;
    x.es = v.es;
    x.ec = v.ec;
    q.push_back(x);
  endtask

  task automatic drive_beat(input int r[8], input int d[8], input logic lst);
    @(negedge clk);
    start_i = 1'b0; valid_i = 1'b1; last_i = lst;
    for (int n = 0; n < 32; n++) begin
      rec_i[8*n +: 8] = 8'(r[n%8]);
      org_i[8*n +: 8] = 8'(r[n%8] + d[n%8]);
    end
  endtask

  task automatic do_start(input logic [1:0] c, input logic [14:0] p);
    @(negedge clk);
    start_i = 1'b1; comp_i = c; pre = p; valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    start_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int lat = -1;
    for (int c = 1; c <= 20; c++) begin
      idle_cycle();
      if (done_o) begin lat = c; break; end
    end
    chk(nm, lat, LAT);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    push_exp(v);
    do_start(v.comp, v.pre);
    for (int b = 0; b < v.nb; b++) drive_beat(v.r, v.d, b == v.nb - 1);
    wait_done(nm);
  endtask

  // Scoreboard: every done_o pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      run_len++;
      if (run_len == 1) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got done_o=1 expected no pending pass");
        end else begin
          e = q.pop_front();
          chk_outs("sb", e);
        end
      end else chk("done_width", run_len, 1);
    end else run_len = 0;
  end

  initial begin
    exp_t hold;
    int ndone;
    vt[0] = '{2'd0, 15'd10, 1, '{80,80,80,80,80,80,80,80}, '{5,5,5,5,5,5,5,5},
              '{160,0,0,0}, '{32,0,0,0}};
    vt[1] = '{2'd0, 15'd24, 1, '{192,200,208,216,224,232,184,255}, '{-3,-3,-3,-3,-3,-3,-3,-3},
              '{-12,-12,-12,-12}, '{4,4,4,4}};
    vt[2] = '{2'd2, 15'h7C1F, 1, '{248,250,252,254,249,251,253,248}, '{1,1,1,1,1,1,1,1},
              '{32,0,0,0}, '{32,0,0,0}};
    vt[3] = '{2'd1, 15'd9396, 1, '{40,48,56,64,39,72,0,255}, '{7,-10,100,-64,5,5,5,-5},
              '{28,-40,400,-256}, '{4,4,4,4}};
    vt[4] = '{2'd0, 15'd0, 3, '{0,8,16,24,7,15,23,31}, '{255,-8,1,-1,3,-15,0,224},
              '{3096,-276,12,2676}, '{24,24,24,24}};
    vt[5] = '{2'd0, 15'd30, 128, '{255,255,255,255,255,255,255,255},
              '{-255,-255,-255,-255,-255,-255,-255,-255}, '{0,-1044480,0,0}, '{0,4096,0,0}};
    vt[6] = '{2'd2, 15'd29696, 1, '{232,240,248,0,8,16,24,255}, '{1,2,3,4,5,6,7,-8},
              '{4,8,-20,0}, '{4,4,8,0}};

    #2;
    chk("rst_sum", int'(sum_o != '0), 0);
    chk("rst_cnt", int'(cnt_o != '0), 0);
    chk("rst_comp", int'(comp_o), 0);
    chk("rst_done", int'(done_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    for (int i = 0; i < 7; i++) begin
      run_vec(vt[i], $sformatf("lat_v%0d", i));
      idle_cycle();
    end

    // Restart mid-pass: only the beat after the second start counts.
    push_exp(vt[0]);
    do_start(vt[4].comp, vt[4].pre);
    for (int b = 0; b < 3; b++) drive_beat(vt[4].r, vt[4].d, 1'b0);
    drive_beat(vt[1].r, vt[1].d, 1'b1);
    start_i = 1'b1; comp_i = 2'd0; pre = 15'd10;
    drive_beat(vt[0].r, vt[0].d, 1'b1);
    wait_done("lat_restart");
    idle_cycle();

    // start_i during OUT is ignored; valid in IDLE is ignored; outputs hold.
    push_exp(vt[0]);
    do_start(vt[0].comp, vt[0].pre);
    drive_beat(vt[0].r, vt[0].d, 1'b1);
    for (int c = 0; c < 20; c++) begin
      idle_cycle();
      if (done_o) begin start_i = 1'b1; comp_i = 2'd2; pre = 15'h7FFF; break; end
    end
    for (int b = 0; b < 3; b++) drive_beat(vt[2].r, vt[2].d, 1'b1);
    repeat (4) idle_cycle();
    hold.comp = 2'd0; hold.es = vt[0].es; hold.ec = vt[0].ec;
    chk_outs("hold", hold);

    // Asynchronous reset mid-pass.
    do_start(2'd2, 15'h7C1F);
    drive_beat(vt[2].r, vt[2].d, 1'b0);
    drive_beat(vt[2].r, vt[2].d, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", int'(sum_o != '0), 0);
    chk("mid_rst_cnt", int'(cnt_o != '0), 0);
    chk("mid_rst_comp", int'(comp_o), 0);
    chk("mid_rst_done", int'(done_o), 0);
    idle_cycle();
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    for (int b = 0; b < 3; b++) begin
      drive_beat(vt[2].r, vt[2].d, 1'b1);
      if (done_o) ndone++;
    end
    for (int c = 0; c < 5; c++) begin
      idle_cycle();
      if (done_o) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1, "timeout");
  end
endmodule
